// File: rtl/psk_pkg.sv
// Shared definitions for the 1-bit PSK coarse phase-search path.
// Holds the search FSM encoding, the NCO phase width and the saturating step helper.
// Pure declarations; no logic, latency or flow control of its own.
package psk_pkg;

  // NCO phase control word width; phase arithmetic wraps modulo 2^PHASE_W.
  localparam int PHASE_W = 12;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_INTEG,
    S_EVAL,
    S_DONE
  } state_e;

  // Adds +1 (up) or -1 (!up) to acc and clamps the result to +/-max_v.
  // The range is kept symmetric so that a magnitude never overflows.
  function automatic int sat_step(input int acc, input logic up, input int max_v);
    int r;
    r = up ? acc + 1 : acc - 1;
    if (r > max_v) begin
      r = max_v;
    end else if (r < -max_v) begin
      r = -max_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/psk_phase_search_if.sv
// Bundle of the phase-search control, sample and result signals.
// Pure wiring: no latency; start is a single-cycle pulse, no backpressure.
// master = the controlling/stimulus side, slave = psk_phase_search.
interface psk_phase_search_if #(
  parameter int ACC_W = 16
);
  import psk_pkg::*;

  // Sweep request and configuration.
  logic                    start;
  phase_t                  phase_base;
  logic [15:0]             integ_len;

  // 1-bit sample stream and NCO reference.
  logic                    sample_bit;
  logic                    ref_bit;

  // Phase drive back to the NCO and search results.
  phase_t                  phase_control_word;
  logic                    busy;
  logic                    done;
  logic                    corr_valid;
  logic signed [ACC_W-1:0] corr_value;
  phase_t                  best_phase;
  logic signed [ACC_W-1:0] best_corr;

  modport master (
    output start, phase_base, integ_len, sample_bit, ref_bit,
    input  phase_control_word, busy, done, corr_valid, corr_value,
           best_phase, best_corr
  );

  modport slave (
    input  start, phase_base, integ_len, sample_bit, ref_bit,
    output phase_control_word, busy, done, corr_valid, corr_value,
           best_phase, best_corr
  );

endinterface

// File: rtl/psk_corr_acc.sv
// Saturating +/-1 correlation accumulator with synchronous clear and enable.
// Latency: one cycle to acc_q; acc_d exposes the value being loaded this edge.
// No backpressure: one term per enabled cycle; clear has priority over enable.
module psk_corr_acc
  import psk_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    agree,
  output logic signed [ACC_W-1:0] acc_d
);

  localparam int MAX_V = (1 << (ACC_W - 1)) - 1;

  logic signed [ACC_W-1:0] acc_q;

  // Next value: clear, else add +1 on agreement / -1 on disagreement, clamped.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = ACC_W'(sat_step(int'(acc_q), agree, MAX_V));
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/psk_phase_search.sv
// Coarse phase search: sweeps the NCO phase word and keeps the best-correlating step.
// Latency: N_STEPS*(SETTLE+L+1)+1 cycles from accepted start to done; all outputs registered.
// No backpressure: start is ignored while busy; rst aborts a sweep immediately.
// Build option PSK_SEARCH_ABS_EN: rank steps by |correlation| so an inverted lock also wins.
module psk_phase_search
  import psk_pkg::*;
#(
  parameter int ACC_W      = 16,
  parameter int N_STEPS    = 16,
  parameter int PHASE_STEP = 256,
  parameter int SETTLE     = 4
) (
  input logic               clk,
  input logic               rst,
  psk_phase_search_if.slave bus
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [11:0] STEP_LAST   = 12'(N_STEPS - 1);
  localparam phase_t      STEP_INC    = phase_t'(PHASE_STEP);
  // Strictly below every reachable metric, so the first step always wins.
  localparam logic signed [ACC_W-1:0] METRIC_FLOOR = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [11:0]             step_q, step_d;
  logic [15:0]             len_q, len_d;
  phase_t                  phase_word_q, phase_word_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    corr_valid_q, corr_valid_d;
  logic signed [ACC_W-1:0] corr_value_q, corr_value_d;
  phase_t                  best_phase_q, best_phase_d;
  logic signed [ACC_W-1:0] best_corr_q, best_corr_d;

  logic                    acc_clr, acc_en;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] metric;
  logic                    settle_end, integ_end, last_step, better;

  psk_corr_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .agree (bus.sample_bit == bus.ref_bit),
    .acc_d (acc_d)
  );

  // Ranking metric of the step just completed (corr_value_q is valid in EVAL).
  always_comb begin
`ifdef PSK_SEARCH_ABS_EN
    // The accumulator range is symmetric, so negation cannot overflow.
    metric = corr_value_q[ACC_W-1] ? -corr_value_q : corr_value_q;
`else
    metric = corr_value_q;
`endif
  end

  // Terminal-count and comparison flags shared by the FSM and the datapath.
  always_comb begin
    settle_end = (cnt_q == SETTLE_LAST);
    integ_end  = (cnt_q == len_q - 16'd1);
    last_step  = (step_q == STEP_LAST);
    better     = (metric > best_corr_q);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SETTLE;
      S_SETTLE: if (settle_end) state_d = S_INTEG;
      S_INTEG:  if (integ_end) state_d = S_EVAL;
      S_EVAL:   state_d = last_step ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: counters, phase drive, result registers and accumulator control.
  always_comb begin
    cnt_d        = cnt_q;
    step_d       = step_q;
    len_d        = len_q;
    phase_word_d = phase_word_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    corr_valid_d = 1'b0;
    corr_value_d = corr_value_q;
    best_phase_d = best_phase_q;
    best_corr_d  = best_corr_q;
    acc_clr      = 1'b1;
    acc_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // A zero length still integrates one sample per step.
          len_d        = (bus.integ_len == 16'd0) ? 16'd1 : bus.integ_len;
          phase_word_d = bus.phase_base;
          busy_d       = 1'b1;
          cnt_d        = '0;
          step_d       = '0;
          best_phase_d = bus.phase_base;
          best_corr_d  = METRIC_FLOOR;
        end
      end
      S_SETTLE: begin
        // Accumulator stays cleared while the NCO pipeline catches up.
        cnt_d = settle_end ? 16'd0 : cnt_q + 16'd1;
      end
      S_INTEG: begin
        acc_clr = 1'b0;
        acc_en  = 1'b1;
        cnt_d   = integ_end ? 16'd0 : cnt_q + 16'd1;
        if (integ_end) begin
          // Publish the total including this cycle's sample.
          corr_valid_d = 1'b1;
          corr_value_d = acc_d;
        end
      end
      S_EVAL: begin
        // Strict compare: on a tie the earlier step is kept.
        if (better) begin
          best_phase_d = phase_word_q;
          best_corr_d  = metric;
        end
        if (last_step) begin
          // Park the NCO on the winner so tracking can start from it.
          phase_word_d = best_phase_d;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else begin
          phase_word_d = phase_word_q + STEP_INC;
          step_d       = step_q + 12'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      step_q       <= '0;
      len_q        <= 16'd1;
      phase_word_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      corr_valid_q <= 1'b0;
      corr_value_q <= '0;
      best_phase_q <= '0;
      best_corr_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      len_q        <= len_d;
      phase_word_q <= phase_word_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      corr_valid_q <= corr_valid_d;
      corr_value_q <= corr_value_d;
      best_phase_q <= best_phase_d;
      best_corr_q  <= best_corr_d;
    end
  end

  assign bus.phase_control_word = phase_word_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.corr_valid         = corr_valid_q;
  assign bus.corr_value         = corr_value_q;
  assign bus.best_phase         = best_phase_q;
  assign bus.best_corr          = best_corr_q;

endmodule

// File: tb/tb_psk_phase_search.sv
// Self-checking bench for psk_phase_search with a cycle-indexed behavioural model.
// The model derives every expectation from the sweep timing formula and recorded bits.
// Honours PSK_SEARCH_ABS_EN for the ranking metric.
module tb_psk_phase_search;
  import psk_pkg::*;

  localparam int ACC_W = 8;
  localparam int N     = 16;
  localparam int STEP  = 256;
  localparam int S     = 4;
  localparam int MAXV  = 127;

`ifdef PSK_SEARCH_ABS_EN
  localparam int EXP_INV_BEST = 50;
`else
  localparam int EXP_INV_BEST = -50;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psk_phase_search_if #(.ACC_W(ACC_W)) bus ();

  psk_phase_search #(
    .ACC_W      (ACC_W),
    .N_STEPS    (N),
    .PHASE_STEP (STEP),
    .SETTLE     (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Model state for the sweep in flight.
  bit m_active  = 1'b0;
  bit free_run  = 1'b0;
  int stim_mode = 2;
  int m_t, m_L, m_P, m_base, m_acc, m_best_c, m_best_p, m_last_corr, m_nvalid, m_done_t;
  int m_first_pcw [3];

  // Stimulus: sample/ref bits per cycle; mode 3 emulates an NCO with 3-cycle latency.
  initial begin
    logic [11:0] ph, h1, h2, h3, ta, ts;
    bit b;
    ph = '0; h1 = '0; h2 = '0; h3 = '0;
    bus.sample_bit = 1'b0;
    bus.ref_bit    = 1'b0;
    forever begin
      @(posedge clk); #1;
      h3 = h2; h2 = h1; h1 = bus.phase_control_word;
      ph = ph + 12'd61;
      b  = 1'($urandom);
      case (stim_mode)
        0: begin bus.sample_bit = b;  bus.ref_bit = b; end
        1: begin bus.sample_bit = ~b; bus.ref_bit = b; end
        2: begin bus.sample_bit = b;  bus.ref_bit = 1'($urandom); end
        default: begin
          ta = ph + h3;
          ts = ph + 12'h300;
          bus.ref_bit    = ta[11];
          bus.sample_bit = ts[11];
        end
      endcase
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin : cmp
    int j, pos, met, exp_pcw;
    if (rst || free_run) begin
    end else if (!m_active) begin
      check("idle_busy", int'(bus.busy), 0);
      check("idle_done", int'(bus.done), 0);
      check("idle_corr_valid", int'(bus.corr_valid), 0);
    end else begin
      m_t++;
      if (bus.corr_valid) m_nvalid++;
      if (bus.done && m_done_t < 0) m_done_t = m_t;
      if (m_t >= 1 && m_t <= N * m_P) begin
        j       = (m_t - 1) / m_P;
        pos     = (m_t - 1) % m_P + 1;
        exp_pcw = (m_base + j * STEP) % 4096;
        if (pos == 1) m_acc = 0;
        if (pos == 1 && j < 3) m_first_pcw[j] = int'(bus.phase_control_word);
        check("busy", int'(bus.busy), 1);
        check("done_early", int'(bus.done), 0);
        check("pcw", int'(bus.phase_control_word), exp_pcw);
        if (pos > S && pos <= S + m_L) begin
          m_acc += (bus.sample_bit == bus.ref_bit) ? 1 : -1;
          if (m_acc > MAXV) m_acc = MAXV;
          if (m_acc < -MAXV) m_acc = -MAXV;
        end
        check("corr_valid", int'(bus.corr_valid), int'(pos == m_P));
        if (pos == m_P) begin
          check("corr_value", int'(bus.corr_value), m_acc);
`ifdef PSK_SEARCH_ABS_EN
          met = (m_acc < 0) ? -m_acc : m_acc;
`else
          met = m_acc;
`endif
          if (met > m_best_c) begin
            m_best_c = met;
            m_best_p = exp_pcw;
          end
          m_last_corr = m_acc;
        end
      end else if (m_t == N * m_P + 1) begin
        check("done_busy", int'(bus.busy), 0);
        check("done_pulse", int'(bus.done), 1);
        check("done_corr_valid", int'(bus.corr_valid), 0);
        check("best_phase", int'(bus.best_phase), m_best_p);
        check("best_corr", int'(bus.best_corr), m_best_c);
        check("pcw_parked", int'(bus.phase_control_word), m_best_p);
        m_active = 1'b0;
      end
    end
  end

  // One sweep; extra_at >= 0 pulses start again that many cycles into the sweep.
  task automatic sweep(input int base, input int len, input int md, input int extra_at);
    @(posedge clk); #1;
    stim_mode      = md;
    bus.start      = 1'b1;
    bus.phase_base = 12'(base);
    bus.integ_len  = 16'(len);
    m_base   = base;
    m_L      = (len == 0) ? 1 : len;
    m_P      = S + m_L + 1;
    m_t      = -1;
    m_acc    = 0;
    m_best_c = -1000000;
    m_best_p = base;
    m_nvalid = 0;
    m_done_t = -1;
    m_active = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.phase_base = 12'($urandom);
    bus.integ_len  = 16'($urandom);
    for (int c = 0; c < N * m_P + 20 && m_active; c++) begin
      @(posedge clk); #1;
      bus.start = (c == extra_at);
    end
    bus.start = 1'b0;
    check("sweep_finished", int'(m_active), 0);
    m_active = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.phase_base = '0;
    bus.integ_len  = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pcw", int'(bus.phase_control_word), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_corr_valid", int'(bus.corr_valid), 0);
    check("rst_corr_value", int'(bus.corr_value), 0);
    check("rst_best_phase", int'(bus.best_phase), 0);
    check("rst_best_corr", int'(bus.best_corr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All samples agree: every step +100, tie keeps the first phase.
    sweep(12'h123, 100, 0, -1);
    check("tied_best_phase", int'(bus.best_phase), 'h123);
    check("tied_best_corr", int'(bus.best_corr), 100);
    check("tied_last_corr", m_last_corr, 100);
    check("tied_nvalid", m_nvalid, 16);
    check("tied_done_cycle", m_done_t, 1681);

    // Inverted reference.
    sweep(12'h040, 50, 1, -1);
    check("inv_last_corr", m_last_corr, -50);
    check("inv_best_corr", int'(bus.best_corr), EXP_INV_BEST);
    check("inv_best_phase", int'(bus.best_phase), 'h040);
    check("inv_done_cycle", m_done_t, 881);

    // Second NCO at phase 0x300 drives the samples.
    sweep(0, 120, 3, -1);
    check("nco_best_phase", int'(bus.best_phase), 'h300);
    check("nco_best_corr", int'(bus.best_corr), 120);
    @(negedge clk);
    check("nco_pcw_after_done", int'(bus.phase_control_word), 'h300);

    // Phase wrap.
    sweep(12'hF00, 7, 2, -1);
    check("wrap_pcw0", m_first_pcw[0], 'hF00);
    check("wrap_pcw1", m_first_pcw[1], 'h000);
    check("wrap_pcw2", m_first_pcw[2], 'h100);

    // Saturation at +127.
    sweep(12'h555, 300, 0, -1);
    check("sat_last_corr", m_last_corr, 127);
    check("sat_best_corr", int'(bus.best_corr), 127);

    // Zero length integrates one sample per step.
    sweep(12'h0AA, 0, 2, -1);
    check("len0_done_cycle", m_done_t, 97);
    check("len0_last_mag", (m_last_corr < 0) ? -m_last_corr : m_last_corr, 1);

    // Start while busy is ignored.
    sweep(12'h200, 10, 2, 20);
    check("busy_start_done_cycle", m_done_t, 241);

    // Reset in the middle of integration.
    free_run = 1'b1;
    @(posedge clk); #1;
    stim_mode      = 0;
    bus.start      = 1'b1;
    bus.phase_base = 12'h321;
    bus.integ_len  = 16'd50;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_before", int'(bus.busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_pcw", int'(bus.phase_control_word), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_corr_valid", int'(bus.corr_valid), 0);
    check("midrst_corr_value", int'(bus.corr_value), 0);
    check("midrst_best_phase", int'(bus.best_phase), 0);
    check("midrst_best_corr", int'(bus.best_corr), 0);
    free_run = 1'b0;

    // Randomized sweeps.
    for (int r = 0; r < 4; r++) begin
      sweep(int'($urandom_range(0, 4095)), int'($urandom_range(1, 30)), int'($urandom_range(0, 2)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
